// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: FSM states and pattern-entry layout.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Counter widths.
  localparam int PWM_W  = 4;
  localparam int HOLD_W = 8;

  // Pattern entry: {last[14], led_mask[13:12], duty[11:8], hold[7:0]}.
  localparam int DUTY_W   = 4;
  localparam int MASK_W   = 2;
  localparam int ENTRY_W  = 15;
  localparam int HOLD_LSB = 0;
  localparam int DUTY_LSB = 8;
  localparam int MASK_LSB = 12;
  localparam int LAST_BIT = 14;

endpackage

// File: rtl/tick_gen.sv
// Step-tick prescaler: counts 0..PRESCALE-1 while enabled, one-cycle tick at the top.
module tick_gen #(
  parameter int PRESCALE = 20800
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count_reg;

  // Prescale counter; clear restarts the tick phase when a sequence begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= (count_reg == CNT_LAST) ? '0 : count_reg + CNT_W'(1);
    end
  end

  assign tick = enable && (count_reg == CNT_LAST);

endmodule

// File: rtl/led_sequencer.sv
// Table-driven two-LED pattern sequencer with PWM dimming, pause and looping.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter  int PRESCALE  = 20800,
  parameter  int NUM_STEPS = 8,
  localparam int IDX_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               loop_en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [IDX_W-1:0]   cfg_index,
  input  logic [ENTRY_W-1:0] cfg_data,
  output logic [MASK_W-1:0]  led,
  output logic               busy,
  output logic [IDX_W-1:0]   step,
  output logic               done
);

  logic [1:0]         rst_sync_reg;
  logic               rst_sync_n;
  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   step_reg;
  logic [IDX_W-1:0]   step_inc;
  logic [HOLD_W-1:0]  hold_reg;
  logic [PWM_W-1:0]   pwm_reg;
  logic [MASK_W-1:0]  led_reg;
  logic               done_reg;
  logic               tick;
  logic               tick_en;
  logic               start_accept;
  logic               run_now;
  logic               entry_end;
  logic [ENTRY_W-1:0] table_mem [NUM_STEPS];

  // Reset asserts immediately but releases only after two clk edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end
  assign rst_sync_n = rst_sync_reg[1];

  assign step_inc     = step_reg + IDX_W'(1);
  assign start_accept = (state_reg == ST_IDLE) && start && !stop;
  assign run_now      = (state_reg == ST_RUN) && !stop;
  assign tick_en      = (state_reg == ST_RUN);
  assign entry_end    = run_now && tick && (hold_reg == '0);

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_sync_n),
    .enable(tick_en),
    .clear (start_accept),
    .tick  (tick)
  );

  // Pattern table: writable only while idle, deliberately not reset.
  always_ff @(posedge clk) begin
    if (cfg_valid && cfg_ready) begin
      table_mem[cfg_index] <= cfg_data;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: stop beats completion, completion beats pause.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_accept) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (entry_end && table_mem[step_reg][LAST_BIT] && !loop_en) begin
          state_next = ST_IDLE;
        end else if (pause) begin
          state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (!pause) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Step/hold/PWM datapath; everything holds its value outside RUN.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      step_reg <= '0;
      hold_reg <= '0;
      pwm_reg  <= '0;
      led_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      led_reg  <= '0;
      if (start_accept) begin
        step_reg <= '0;
        hold_reg <= table_mem[0][HOLD_LSB +: HOLD_W];
        pwm_reg  <= '0;
      end else if (run_now) begin
        pwm_reg <= pwm_reg + PWM_W'(1);
        led_reg <= table_mem[step_reg][MASK_LSB +: MASK_W]
                 & {MASK_W{pwm_reg < table_mem[step_reg][DUTY_LSB +: DUTY_W]}};
        if (tick) begin
          if (hold_reg != '0) begin
            hold_reg <= hold_reg - HOLD_W'(1);
          end else if (!table_mem[step_reg][LAST_BIT]) begin
            step_reg <= step_inc;
            hold_reg <= table_mem[step_inc][HOLD_LSB +: HOLD_W];
          end else if (loop_en) begin
            step_reg <= '0;
            hold_reg <= table_mem[0][HOLD_LSB +: HOLD_W];
          end else begin
            done_reg <= 1'b1;
          end
        end
      end
    end
  end

  // The LED register is only shown while running, so PAUSE/IDLE are dark at once.
  assign led       = (state_reg == ST_RUN) ? led_reg : '0;
  assign busy      = (state_reg != ST_IDLE);
  assign cfg_ready = (state_reg == ST_IDLE);
  assign step      = step_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed scenarios plus randomized traffic, checked against a timing-level model.
module tb_led_sequencer;

  localparam int P  = 4;
  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;
  logic          loop_en = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [IW-1:0] cfg_index = '0;
  logic [14:0]   cfg_data = '0;
  logic [1:0]    led;
  logic          busy;
  logic [IW-1:0] step;
  logic          done;

  led_sequencer #(.PRESCALE(P), .NUM_STEPS(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .loop_en  (loop_en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_index(cfg_index),
    .cfg_data (cfg_data),
    .led      (led),
    .busy     (busy),
    .step     (step),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: 0 idle, 1 running, 2 paused. An entry lasts (hold+1)*P running cycles;
  // pwm is the running-cycle count modulo 16.
  int          m_st;
  int          m_step;
  int          m_left;
  int          m_pwm;
  int          m_led;
  bit          m_done;
  logic [14:0] m_tbl [N];

  function automatic logic [14:0] ent(input bit last, input logic [1:0] mask,
                                      input int duty, input int hold);
    return {last, mask, 4'(duty), 8'(hold)};
  endfunction

  function automatic int hold_of(input logic [14:0] e); return int'(e[7:0]);   endfunction
  function automatic int duty_of(input logic [14:0] e); return int'(e[11:8]);  endfunction
  function automatic int mask_of(input logic [14:0] e); return int'(e[13:12]); endfunction
  function automatic bit last_of(input logic [14:0] e); return e[14];          endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_step = 0; m_left = 0; m_pwm = 0; m_led = 0; m_done = 0;
  endtask

  task automatic check_outputs();
    chk("led", led, m_led);
    chk("busy", busy, m_st != 0);
    chk("step", step, m_step);
    chk("done", done, m_done);
    chk("cfg_ready", cfg_ready, m_st == 0);
  endtask

  // Advance the model across one clock edge using this cycle's inputs.
  task automatic model_edge();
    int nl;
    bit nd;
    int cur;
    logic [14:0] e;
    nl = 0; nd = 0; cur = m_st;
    case (cur)
      0: begin
        if (start && !stop) begin
          m_st = 1; m_step = 0; m_pwm = 0;
          m_left = (hold_of(m_tbl[0]) + 1) * P;
        end
        if (cfg_valid) m_tbl[cfg_index] = cfg_data;
      end
      1: begin
        if (stop) begin
          m_st = 0;
        end else begin
          e = m_tbl[m_step];
          if (m_pwm < duty_of(e)) nl = mask_of(e);
          m_pwm = (m_pwm + 1) % 16;
          m_left--;
          if (m_left == 0) begin
            if (!last_of(e)) begin
              m_step = (m_step + 1) % N;
              m_left = (hold_of(m_tbl[m_step]) + 1) * P;
            end else if (loop_en) begin
              m_step = 0;
              m_left = (hold_of(m_tbl[0]) + 1) * P;
            end else begin
              m_st = 0; nd = 1;
            end
          end
          if (m_st == 1 && pause) m_st = 2;
        end
      end
      default: begin
        if (stop) m_st = 0;
        else if (!pause) m_st = 1;
      end
    endcase
    m_led  = (m_st == 1) ? nl : 0;
    m_done = nd;
  endtask

  // One clock: check outputs mid-cycle, then step the model at the edge.
  task automatic cycle();
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wr(input int idx, input logic [14:0] d);
    cfg_valid = 1'b1; cfg_index = IW'(idx); cfg_data = d;
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cycle(); stop = 1'b0;
  endtask

  initial begin
    int s0, s1, dn, nb, on, split, cnt;

    // Power-up reset.
    #1 rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    check_outputs();
    rst_n = 1'b1;
    repeat (4) cycle();
    $display("reset: released");

    // Two-entry table, non-looping run.
    wr(0, ent(0, 2'b01, 15, 1));
    wr(1, ent(1, 2'b10, 8, 0));
    for (int i = 2; i < N; i++) wr(i, ent(0, 2'b00, 0, 0));
    loop_en = 1'b0;
    pulse_start();
    s0 = 0; s1 = 0; dn = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy && step == 0) s0++;
      if (busy && step == 1) s1++;
      if (done) dn++;
      cycle();
    end
    chk("step0_cycles", s0, 8);
    chk("step1_cycles", s1, 4);
    chk("done_pulses", dn, 1);
    chk("idle_after_done", busy, 0);
    $display("single run: step0=%0d step1=%0d done=%0d", s0, s1, dn);

    // Same table, looping.
    loop_en = 1'b1;
    pulse_start();
    dn = 0; nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dn++;
      if (!busy) nb++;
      cycle();
    end
    chk("loop_no_done", dn, 0);
    chk("loop_busy_held", nb, 0);
    pulse_stop();
    loop_en = 1'b0;
    $display("loop run: done=%0d idle_cycles=%0d", dn, nb);

    // PWM duty 4 on both LEDs.
    wr(0, ent(1, 2'b11, 4, 255));
    pulse_start();
    cycle();
    on = 0; split = 0;
    for (int i = 0; i < 64; i++) begin
      if (led == 2'b11) on++;
      if (led == 2'b01 || led == 2'b10) split++;
      cycle();
    end
    chk("duty4_on_cycles", on, 16);
    chk("duty4_split", split, 0);
    pulse_stop();
    $display("pwm duty4: on=%0d split=%0d", on, split);

    // Pause for 10 cycles inside entry 0.
    wr(0, ent(0, 2'b11, 15, 3));
    wr(1, ent(1, 2'b01, 8, 2));
    pulse_start();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin cnt += busy; cycle(); end
    pause = 1'b1;
    cnt += busy; cycle();
    for (int i = 0; i < 9; i++) begin
      cnt += busy;
      chk("pause_led", led, 0);
      chk("pause_step", step, 0);
      cycle();
    end
    pause = 1'b0;
    for (int i = 0; i < 40; i++) begin cnt += busy; cycle(); end
    chk("pause_busy_cycles", cnt, 38);
    $display("pause: busy_cycles=%0d", cnt);

    // start+stop together in IDLE, then configuration attempts while running.
    start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    cycle();
    chk("start_stop_idle", busy, 0);
    wr(0, ent(1, 2'b11, 15, 0));
    loop_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1; cfg_index = '0; cfg_data = ent(0, 2'b00, 0, 5);
      chk("run_cfg_ready", cfg_ready, 0);
      cycle();
    end
    cfg_valid = 1'b0;
    pulse_stop();
    loop_en = 1'b0;
    pulse_start();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin cnt += busy; cycle(); end
    chk("cfg_blocked_len", cnt, 4);
    $display("cfg during run: entry0 run length=%0d", cnt);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 15) == 0);
      stop      = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      if ($urandom_range(0, 199) == 0) loop_en = ~loop_en;
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_index = IW'($urandom);
      cfg_data  = {($urandom_range(0, 3) == 0), 2'($urandom), 4'($urandom),
                   8'($urandom_range(0, 3))};
      cycle();
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0; cfg_valid = 1'b0;
    pulse_stop();
    cycle();
    $display("random: 3000 cycles, %0d compared so far", n_cmp);

    // Asynchronous reset in the middle of step 3.
    for (int i = 0; i < N; i++) wr(i, ent(0, 2'b11, 8, 0));
    pulse_start();
    for (int i = 0; i < 50 && m_step != 3; i++) cycle();
    chk("reach_step3", step, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step", step, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    model_reset();
    check_outputs();
    rst_n = 1'b1;
    repeat (4) cycle();
    pulse_start();
    repeat (12) cycle();
    pulse_stop();
    cycle();
    $display("mid-run reset: recovered");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 20800: clk cycles per step tick (100 Hz at 2.08 MHz).
REQ-002 SHALL have parameter NUM_STEPS, default 8: pattern table depth, power of two.
REQ-003 SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-004 clk  in  1  system clock from the internal oscillator.
REQ-005 rst_n  in  1  async active-low reset.
REQ-006 start  in  1  one-cycle pulse: begin sequence at step 0.
REQ-007 stop  in  1  one-cycle pulse: abort sequence.
REQ-008 pause  in  1  level: freeze sequence while high.
REQ-009 loop_en  in  1  level: restart at step 0 after last entry.
REQ-010 cfg_valid  in  1  table write request.
REQ-011 cfg_ready  out  1  table write accepted when high with cfg_valid.
REQ-012 cfg_index  in  log2(NUM_STEPS)  table entry address.
REQ-013 cfg_data  in  15  {last[14], led_mask[13:12], duty[11:8], hold[7:0]}.
REQ-014 led  out  2  LED drive, pin-level active-high.
REQ-015 busy  out  1  high in RUN or PAUSE.
REQ-016 step  out  log2(NUM_STEPS)  current table index.
REQ-017 done  out  1  one-cycle pulse on non-looping completion.

Function
REQ-018 FSM states IDLE, RUN, PAUSE; start in IDLE -> RUN; pause high in RUN -> PAUSE; pause low in PAUSE -> RUN; stop in RUN/PAUSE -> IDLE.
REQ-019 stop SHALL win over start and pause in the same cycle; start in RUN/PAUSE SHALL be ignored.
REQ-020 cfg_ready SHALL be 1 only in IDLE; write occurs on cfg_valid & cfg_ready, visible to a start the following cycle.
REQ-021 On RUN entry from IDLE: step=0, prescaler=0, pwm counter=0, hold counter=entry[0].hold.
REQ-022 Prescaler counts 0..PRESCALE-1 in RUN only; tick asserted for one cycle when count==PRESCALE-1, then wraps to 0.
REQ-023 Each entry SHALL be displayed for hold+1 ticks; hold counter decrements on tick; tick with hold counter==0 ends the entry.
REQ-024 Entry end, last=0: step+1 (wrapping at NUM_STEPS-1 -> 0), hold counter reloads from new entry, same cycle.
REQ-025 Entry end, last=1, loop_en=1: step=0, stay RUN; loop_en=0: -> IDLE, done=1 for exactly that cycle.
REQ-026 4-bit pwm counter free-runs (wraps 15->0) in RUN; led[i]=mask[i] & (pwm < duty), registered, one cycle latency; duty 0 = off, duty 15 = 15/16.
REQ-027 In PAUSE: prescaler, hold, pwm counters and step frozen; led=0.
REQ-028 In IDLE: led=0, busy=0, step retains last value until next start.

Reset
REQ-029 rst_n low SHALL force IDLE, led=0, busy=0, step=0, done=0, cfg_ready=1, all counters 0, immediately and asynchronously, including mid-sequence.
REQ-030 Table contents SHALL NOT be reset; an unwritten entry is undefined until written.
REQ-031 Reset release SHALL be synchronised to clk before use.

Structure
REQ-032 Shared package led_seq_pkg SHALL hold state enum, entry field widths/offsets, PWM width 4, HOLD width 8.
REQ-033 Prescaler SHALL be sub-module tick_gen (parameter PRESCALE, inputs clk, rst_n, enable, clear; output tick).
REQ-034 Table SHALL be a register array inside led_sequencer, no vendor RAM primitive.

Verification (PRESCALE=4)
REQ-035 Reset during RUN at step 3 -> led=0, busy=0, step=0, cfg_ready=1 same cycle as rst_n fall.
REQ-036 Entries 0,1 = {mask 2'b01, duty 15, hold 1} and {last, mask 2'b10, duty 8, hold 0}, loop_en=0, start -> step 0 for 8 cycles, step 1 for 4, then done pulse, IDLE.
REQ-037 Same table, loop_en=1 -> step sequence 0,1,0,1 repeats, no done pulse, busy stays 1.
REQ-038 duty 4, mask 2'b11 -> led=2'b11 exactly 4 of every 16 cycles, both bits identical.
REQ-039 pause high 10 cycles mid-entry -> led=0, step unchanged; after release, remaining hold time equals time left at pause.
REQ-040 start and stop same cycle in IDLE -> stays IDLE; cfg_valid during RUN -> cfg_ready=0, table unchanged.
